// File: rtl/instr_encoder.sv
// RV32I instruction word encoder: captures one encode request, validates it,
// and emits the encoded word to a sequential write port until DEPTH words are out.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op_class,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [31:0]              imm,
    output logic                     wr_en,
    output logic [31:0]              wr_addr,
    output logic [31:0]              wr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     err
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] CL_R    = 3'd0;
    localparam logic [2:0] CL_LOAD = 3'd1;
    localparam logic [2:0] CL_ALUI = 3'd2;
    localparam logic [2:0] CL_JALR = 3'd3;
    localparam logic [2:0] CL_S    = 3'd4;
    localparam logic [2:0] CL_B    = 3'd5;
    localparam logic [2:0] CL_LUI  = 3'd6;
    localparam logic [2:0] CL_JAL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    function automatic logic [6:0] opcode_of(input logic [2:0] cls);
        logic [6:0] op;
        case (cls)
            CL_R:    op = 7'b0110011;
            CL_LOAD: op = 7'b0000011;
            CL_ALUI: op = 7'b0010011;
            CL_JALR: op = 7'b1100111;
            CL_S:    op = 7'b0100011;
            CL_B:    op = 7'b1100011;
            CL_LUI:  op = 7'b0110111;
            CL_JAL:  op = 7'b1101111;
            default: op = 7'b0000000;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] encode(input logic [2:0] cls, input logic [2:0] f3,
                                           input logic f7, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [31:0] im);
        logic [6:0]  op;
        logic [31:0] w;
        op = opcode_of(cls);
        w  = 32'h0000_0000;
        case (cls)
            CL_R:    w = {1'b0, f7, 5'b00000, s2, s1, f3, d, op};
            CL_LOAD: w = {im[11:0], s1, f3, d, op};
            CL_ALUI: begin
                // shifts carry the shift amount plus the arithmetic/logical select bit
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    w = {1'b0, f7, 5'b00000, im[4:0], s1, f3, d, op};
                end else begin
                    w = {im[11:0], s1, f3, d, op};
                end
            end
            CL_JALR: w = {im[11:0], s1, 3'b000, d, op};
            CL_S:    w = {im[11:5], s2, s1, f3, im[4:0], op};
            CL_B:    w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            CL_LUI:  w = {im[31:12], d, op};
            CL_JAL:  w = {im[20], im[10:1], im[11], im[19:12], d, op};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic is_legal(input logic [2:0] cls, input logic [2:0] f3,
                                      input logic im0);
        logic ok;
        case (cls)
            CL_B:    ok = ((f3 == 3'b000) || (f3 == 3'b001)) && !im0;
            CL_JAL:  ok = !im0;
            CL_S,
            CL_LOAD: ok = (f3 <= 3'b010);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    state_t          state_r, state_next_s;
    logic [2:0]      cls_r, f3_r;
    logic            f7b5_r;
    logic [4:0]      rd_r, rs1_r, rs2_r;
    logic [31:0]     imm_r;
    logic [CW-1:0]   count_r, count_next_s;
    logic            full_r, full_next_s;
    logic            in_ready_r, wr_en_r, err_r;
    logic [31:0]     wr_addr_r, wr_data_r;
    logic            accept_s, legal_s;
    logic [31:0]     enc_s, addr_s;

    assign accept_s = in_valid & in_ready_r;
    assign legal_s  = is_legal(cls_r, f3_r, imm_r[0]);
    assign enc_s    = encode(cls_r, f3_r, f7b5_r, rd_r, rs1_r, rs2_r, imm_r);
    assign addr_s   = BASE_ADDR + {{(30-CW){1'b0}}, count_r, 2'b00};

    // Next-state, count and full computation
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = ENCODE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ENCODE: begin
                if (legal_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                state_next_s = IDLE;
                if (count_r != DEPTH_C) begin
                    count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    count_next_s = count_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
        full_next_s = (count_next_s == DEPTH_C);
    end

    // FSM state, count, full and ready registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= '0;
            full_r     <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            count_r    <= count_next_s;
            full_r     <= full_next_s;
            in_ready_r <= (state_next_s == IDLE) && !full_next_s;
        end
    end

    // Request field capture on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            cls_r  <= 3'b000;
            f3_r   <= 3'b000;
            f7b5_r <= 1'b0;
            rd_r   <= 5'b00000;
            rs1_r  <= 5'b00000;
            rs2_r  <= 5'b00000;
            imm_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            cls_r  <= op_class;
            f3_r   <= funct3;
            f7b5_r <= funct7b5;
            rd_r   <= rd;
            rs1_r  <= rs1;
            rs2_r  <= rs2;
            imm_r  <= imm;
        end
    end

    // Write-port and error pulses, zeroed outside their single active cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 32'h0000_0000;
            wr_data_r <= 32'h0000_0000;
            err_r     <= 1'b0;
        end else if ((state_r == ENCODE) && legal_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= addr_s;
            wr_data_r <= enc_s;
            err_r     <= 1'b0;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= 32'h0000_0000;
            wr_data_r <= 32'h0000_0000;
            err_r     <= (state_r == ENCODE);
        end
    end

    assign in_ready = in_ready_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign count    = count_r;
    assign full     = full_r;
    assign err      = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of hand-encoded requests checked through a
// scoreboard, plus held-valid, full and mid-operation reset sequences.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op_class = 3'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7b5 = 1'b0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [31:0] imm = 32'h0;
    logic        wr_en, full, err;
    logic [31:0] wr_addr, wr_data;
    logic [2:0]  count;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .funct3(funct3), .funct7b5(funct7b5),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[16];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   exp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] im, input logic e, input logic [31:0] w);
        vec_t v;
        v.cls = c; v.f3 = f3; v.f7 = f7; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.imm = im; v.exp_err = e; v.exp_data = w;
        return v;
    endfunction

    // Output monitor: every err/wr_en pulse must match the oldest expectation
    always @(negedge clk) begin
        if (wr_en || err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: wr_en=%0b err=%0b, expected none", wr_en, err);
            end else begin
                mon_e = sb.pop_front();
                chk("err", {31'b0, err}, {31'b0, mon_e.err});
                chk("wr_en", {31'b0, wr_en}, {31'b0, !mon_e.err});
                chk("latency", cyc, mon_e.due);
                if (!mon_e.err) begin
                    chk("wr_addr", wr_addr, mon_e.addr);
                    chk("wr_data", wr_data, mon_e.data);
                end
            end
        end else begin
            chk("idle_addr", wr_addr, 32'h0);
            chk("idle_data", wr_data, 32'h0);
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.err  = v.exp_err;
        e.addr = v.exp_err ? 32'h0 : BASE + 32'(exp_count * 4);
        e.data = v.exp_data;
        e.due  = cyc + 2;
        sb.push_back(e);
        if (!v.exp_err) exp_count++;
    endtask

    task automatic drive_fields(input vec_t v);
        op_class = v.cls; funct3 = v.f3; funct7b5 = v.f7;
        rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    endtask

    // Returns at the negedge following the accepting edge (the ENCODE cycle)
    task automatic send(input vec_t v, input bit push);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 after 50 cycles, expected 1");
            return;
        end
        drive_fields(v);
        in_valid = 1'b1;
        if (push) push_exp(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        sb.delete();
        exp_count = 0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    // Hold in_valid high for n cycles with fixed fields, counting accepts
    task automatic hold_valid(input vec_t v, input int n, output int acc);
        int since;
        acc = 0;
        since = 99;
        drive_fields(v);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (since == 1 || since == 2) chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
            if (in_ready) begin
                push_exp(v);
                acc++;
                since = 0;
            end
            since++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        vec_t v;
        //             cls   f3    f7    rd     rs1    rs2    imm             err   word
        tbl[0]  = mk(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h002081B3);
        tbl[1]  = mk(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h402081B3);
        tbl[2]  = mk(3'd1, 3'd2, 1'b0, 5'd5, 5'd1, 5'd0, 32'h0000_0008, 1'b0, 32'h0080A283);
        tbl[3]  = mk(3'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h123452B7);
        tbl[4]  = mk(3'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3);
        tbl[5]  = mk(3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0008, 1'b0, 32'h008000EF);
        tbl[6]  = mk(3'd5, 3'd4, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 1'b1, 32'h0);
        tbl[7]  = mk(3'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0000_000C, 1'b0, 32'h0020A623);
        tbl[8]  = mk(3'd2, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00093);
        tbl[9]  = mk(3'd2, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'h0000_0003, 1'b0, 32'h40335293);
        tbl[10] = mk(3'd3, 3'd3, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0000_0000, 1'b0, 32'h00008067);
        tbl[11] = mk(3'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0000_0005, 1'b1, 32'h0);
        tbl[12] = mk(3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0003, 1'b1, 32'h0);
        tbl[13] = mk(3'd4, 3'd3, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0000_0004, 1'b1, 32'h0);
        tbl[14] = mk(3'd1, 3'd4, 1'b0, 5'd5, 5'd1, 5'd0, 32'h0000_0004, 1'b1, 32'h0);
        tbl[15] = mk(3'd2, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h01F09093);

        do_reset();

        for (int i = 0; i < 16; i++) begin
            v = tbl[i];
            if (!v.exp_err && exp_count == DEPTH) do_reset();
            send(v, 1'b1);
            drain();
            chk("count", {29'b0, count}, 32'(exp_count));
            chk("full", {31'b0, full}, {31'b0, (exp_count == DEPTH)});
        end

        // continuous in_valid: one accept every three cycles
        do_reset();
        hold_valid(tbl[0], 9, acc);
        chk("held_accepts", 32'(acc), 32'd3);
        drain();
        chk("held_count", {29'b0, count}, 32'd3);

        // five back-to-back requests into a four-deep block
        do_reset();
        hold_valid(tbl[1], 18, acc);
        chk("full_accepts", 32'(acc), 32'd4);
        drain();
        chk("full_count", {29'b0, count}, 32'd4);
        chk("full_flag", {31'b0, full}, 32'd1);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        hold_valid(tbl[1], 6, acc);
        chk("full_ignored", 32'(acc), 32'd0);
        chk("full_count_hold", {29'b0, count}, 32'd4);

        // reset during ENCODE aborts the in-flight request
        do_reset();
        send(tbl[0], 1'b1);
        drain();
        chk("pre_abort_count", {29'b0, count}, 32'd1);
        send(tbl[2], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", {31'b0, wr_en}, 32'd0);
        chk("abort_err", {31'b0, err}, 32'd0);
        chk("abort_count", {29'b0, count}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        sb.delete();
        exp_count = 0;
        @(negedge clk);
        chk("abort_ready_after", {31'b0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        send(tbl[3], 1'b1);
        drain();
        chk("after_abort_count", {29'b0, count}, 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of the first emitted word.
REQ-002 Parameter DEPTH, default 256, SHALL set the maximum number of words emitted before full.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 in_valid  in  1  SHALL flag a valid encode request.
REQ-006 in_ready  out  1  SHALL flag that the block accepts a request this cycle.
REQ-007 op_class  in  3  SHALL select the format: 0 R, 1 LOAD, 2 ALUI, 3 JALR, 4 S, 5 B, 6 LUI, 7 JAL.
REQ-008 funct3  in  3  SHALL carry instruction funct3.
REQ-009 funct7b5  in  1  SHALL carry instruction bit 30 for R, and for ALUI shifts.
REQ-010 rd, rs1, rs2  in  5 each  SHALL carry register indices.
REQ-011 imm  in  32  SHALL carry the sign-extended immediate (byte offset for B/J; full value for LUI).
REQ-012 wr_en  out  1  SHALL pulse one cycle per emitted word.
REQ-013 wr_addr  out  32  SHALL carry BASE_ADDR + 4*count while wr_en is high.
REQ-014 wr_data  out  32  SHALL carry the encoded instruction while wr_en is high.
REQ-015 count  out  $clog2(DEPTH)+1  SHALL carry the number of words emitted.
REQ-016 full  out  1  SHALL be high when count == DEPTH.
REQ-017 err  out  1  SHALL pulse one cycle when a request is rejected.

Function
REQ-018 FSM states: IDLE, ENCODE, WRITE. IDLE -> ENCODE on accept; ENCODE -> WRITE if legal, else -> IDLE with err; WRITE -> IDLE.
REQ-019 in_ready SHALL be 1 only in IDLE with full low; accept = in_valid & in_ready; all request fields SHALL be registered at accept.
REQ-020 Latency: accept in cycle N -> err or wr_en in cycle N+2. Maximum throughput: one request per 3 cycles.
REQ-021 Opcodes: R 0110011, LOAD 0000011, ALUI 0010011, JALR 1100111, S 0100011, B 1100011, LUI 0110111, JAL 1101111.
REQ-022 R: {1'b0,funct7b5,5'b0, rs2, rs1, funct3, rd, op}.
REQ-023 LOAD/JALR/ALUI: {imm[11:0], rs1, funct3, rd, op}. For ALUI with funct3 001/101 the word SHALL be {1'b0,funct7b5,5'b0, imm[4:0], rs1, funct3, rd, op}. JALR SHALL force funct3 = 000.
REQ-024 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
REQ-025 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
REQ-026 LUI: {imm[31:12], rd, op}. JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-027 Illegal requests, which SHALL give err with no write and no count change:
  - B with funct3 not 000/001.
  - B or J with imm[0] = 1.
  - S or LOAD with funct3 not 000/001/010.
REQ-028 count SHALL increment by 1 in the WRITE cycle and SHALL saturate at DEPTH. When full, in_valid SHALL be ignored and count SHALL hold.
REQ-029 wr_addr and wr_data SHALL be 0 whenever wr_en is low.

Reset
REQ-030 With rst high at a clock edge, the block SHALL enter IDLE and set count, wr_en, wr_addr, wr_data, err and full to 0. in_ready SHALL be 0 during the reset cycle and 1 the cycle after.
REQ-031 A reset asserted in ENCODE or WRITE SHALL abort the request: no wr_en, no err, and count SHALL be 0.

Verification
REQ-032 R: add x3,x1,x2 (class 0, f3 0, f7b5 0) -> wr_data 0x002081B3 at wr_addr BASE_ADDR, 2 cycles after accept. Repeating with f7b5 = 1 -> 0x402081B3 at BASE_ADDR+4.
REQ-033 I and U:
  - lw x5,8(x1) -> 0x0080A283.
  - lui x5 with imm 0x12345000 -> 0x123452B7.
  - count SHALL step 0 -> 1 -> 2.
REQ-034 B and J:
  - beq x1,x2,-4 -> 0xFE208EE3.
  - jal x1,8 -> 0x008000EF.
  - B with f3 100 -> err pulse, no wr_en, count unchanged.
REQ-035 Full: DEPTH = 4, five back-to-back requests -> four writes at BASE..BASE+12. full = 1 after the fourth write. The fifth request is never accepted: in_ready stays low and count stays 4.
REQ-036 Reset mid-operation: rst in the ENCODE cycle of the second request -> no wr_en for it, count = 0. The next request writes to BASE_ADDR.
REQ-037 Handshake: in_valid held high continuously -> in_ready low in ENCODE and WRITE. Exactly one accept per 3 cycles, with no duplicate or dropped words.
